inst_seq_ctrl: RTL and testbench
================================

// Module: inst_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the NPC core: drives fetch, decode, execute, memory and writeback one instruction at a time.
//  Latches the fetched instruction and derives its immediate-extension class code (ext_op) for the immediate generator.
//  Issues the LSU request for load/store; emits one-cycle PC / RF / CSR write strobes; halts on ebreak, traps on illegal op or LSU timeout.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles waiting in MEM_WAIT for lsu_rsp_valid before a bus-error trap (>=1)
//  TO_W         $clog2(MEM_TIMEOUT+1)  timeout counter width (derived localparam, not overridable)
// PORTS
//  clk            in   1   core clock, all logic rising-edge
//  rst            in   1   synchronous reset, active-high
//  ifu_req_valid  out  1   fetch request; held until ifu_req_ready
//  ifu_req_ready  in   1   IFU accepts request
//  ifu_rsp_valid  in   1   instruction word valid, one-cycle pulse
//  ifu_inst       in   32  fetched instruction
//  inst_q         out  32  latched instruction, stable DECODE..WB
//  ext_op         out  4   imm class: lui 8, auipc 9, jal 7, jalr 0, branch 6, load 1, store 5, op-imm 2, op a, system 4, illegal/none f
//  lsu_req_valid  out  1   memory request; held until lsu_req_ready
//  lsu_req_wen    out  1   1 = store, 0 = load; valid with lsu_req_valid
//  lsu_req_ready  in   1   LSU accepts request
//  lsu_rsp_valid  in   1   load data / store ack, one-cycle pulse
//  pc_we          out  1   PC update strobe
//  rf_we          out  1   regfile write strobe
//  csr_we         out  1   CSR write strobe
//  halt           out  1   sticky: ebreak retired
//  trap           out  1   sticky: illegal opcode or LSU timeout
//  trap_cause     out  2   0 none, 1 illegal, 2 LSU timeout
// BEHAVIOUR
//  States: RESET, FETCH, WAIT_I, DECODE, EXEC, MEM, MEM_WAIT, WB, HALT, TRAP.
//  - rst (any state, mid-instruction included): next state RESET.
//    All outputs 0, except ext_op=4'hf; inst_q=0; timeout counter=0.
//  - RESET -> FETCH after 1 cycle.
//  - FETCH: ifu_req_valid=1. On ifu_req_ready -> WAIT_I. ifu_rsp_valid is ignored in RESET/FETCH (stale responses dropped).
//  - WAIT_I: on ifu_rsp_valid, latch inst_q=ifu_inst and ext_op=decode(ifu_inst[6:0]) -> DECODE.
//  - DECODE (1 cycle): ext_op=f -> TRAP (cause 1). inst_q==32'h00100073 -> HALT. Otherwise -> EXEC.
//  - EXEC (1 cycle): load/store -> MEM; all others -> WB.
//  - MEM: lsu_req_valid=1; lsu_req_wen=(ext_op==5). On lsu_req_ready -> MEM_WAIT, counter cleared.
//  - MEM_WAIT: counter +1 per cycle. On lsu_rsp_valid -> WB; rsp wins if it coincides with expiry.
//    Counter==MEM_TIMEOUT without rsp -> TRAP (cause 2).
//  - WB (1 cycle): pc_we=1.
//    rf_we=1 iff class in {lui,auipc,jal,jalr,load,op-imm,op,system} and inst_q[11:7]!=0; never for branch/store.
//    csr_we=1 iff system and funct3!=0. Then -> FETCH.
//  - HALT/TRAP: absorbing until rst; no requests issued; halt/trap held high.
//  - Valids never drop before their ready. Strobes are 1-cycle pulses, asserted only in WB.
//  - Latency, zero-wait IFU/LSU: ALU/branch/jump 5 cycles/instr; load/store 7.
// CONFIGURATION
//  INST_SEQ_PERF_EN defined: adds outputs cyc_cnt[63:0] (+1 every cycle out of RESET)
//    and instret_cnt[63:0] (+1 per WB cycle); both zeroed by rst, wrap at 2^64.
//  INST_SEQ_PERF_EN undefined: those ports and counters do not exist; all other behaviour identical.
// STRUCTURE
//  inst_seq_pkg: state_e enum; opcode localparams (7'b0110111...); ext_op codes EXT_LUI..EXT_ILL; ebreak constant.
//  Sub-module inst_class_dec: combinational opcode -> ext_op / class flags (is_load, is_store, writes_rd, is_csr).
//  The FSM, timeout counter and perf counters stay in inst_seq_ctrl.
// TESTING
//  1. addi x1,x0,5 (0x00500093), ready/rsp immediate
//     -> ext_op=2 from DECODE; pc_we=rf_we=1 in cycle 5 only; ifu_req_valid again in cycle 6.
//  2. sw (0x0020a023), lsu_req_ready delayed 3 cycles
//     -> lsu_req_valid/lsu_req_wen held all 3 cycles; WB has pc_we=1, rf_we=0.
//  3. lw, lsu_rsp_valid never arrives (MEM_TIMEOUT=4)
//     -> trap=1, trap_cause=2 after 4 MEM_WAIT cycles; no further ifu_req_valid.
//  4. opcode 7'b1111111
//     -> TRAP cause 1 at DECODE+1; ebreak 0x00100073 -> halt=1, pc_we never pulses.
//  5. rst during MEM_WAIT, then a stale lsu_rsp_valid/ifu_rsp_valid
//     -> RESET->FETCH; stale pulses ignored; next instruction executes normally.
//  6. INST_SEQ_PERF_EN, 3 back-to-back addi
//     -> instret_cnt=3, cyc_cnt=16 at end of 3rd WB.

Source files
------------

// File: rtl/inst_seq_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer:
// FSM state encoding, RV32 major opcodes, immediate-class codes and trap causes.
package inst_seq_pkg;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_FETCH,
        ST_WAIT_I,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_MEM_WAIT,
        ST_WB,
        ST_HALT,
        ST_TRAP
    } state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Immediate-extension class codes consumed by the immediate generator
    localparam logic [3:0] EXT_JALR   = 4'h0;
    localparam logic [3:0] EXT_LOAD   = 4'h1;
    localparam logic [3:0] EXT_OPIMM  = 4'h2;
    localparam logic [3:0] EXT_SYSTEM = 4'h4;
    localparam logic [3:0] EXT_STORE  = 4'h5;
    localparam logic [3:0] EXT_BRANCH = 4'h6;
    localparam logic [3:0] EXT_JAL    = 4'h7;
    localparam logic [3:0] EXT_LUI    = 4'h8;
    localparam logic [3:0] EXT_AUIPC  = 4'h9;
    localparam logic [3:0] EXT_OP     = 4'ha;
    localparam logic [3:0] EXT_ILL    = 4'hf;

    localparam logic [31:0] INST_EBREAK = 32'h00100073;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_LSU_TO  = 2'd2;

endpackage

// File: rtl/inst_class_dec.sv
// Combinational opcode classifier: immediate class code plus the per-class
// flags the sequencer needs (memory direction, rd write, CSR write).
module inst_class_dec
    import inst_seq_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic [3:0] ext_op,
    output logic       is_load,
    output logic       is_store,
    output logic       writes_rd,
    output logic       is_csr
);

    always_comb begin
        ext_op    = EXT_ILL;
        writes_rd = 1'b1;
        case (opcode)
            OPC_LUI:    ext_op = EXT_LUI;
            OPC_AUIPC:  ext_op = EXT_AUIPC;
            OPC_JAL:    ext_op = EXT_JAL;
            OPC_JALR:   ext_op = EXT_JALR;
            OPC_LOAD:   ext_op = EXT_LOAD;
            OPC_OPIMM:  ext_op = EXT_OPIMM;
            OPC_OP:     ext_op = EXT_OP;
            OPC_SYSTEM: ext_op = EXT_SYSTEM;
            OPC_BRANCH: begin
                ext_op    = EXT_BRANCH;
                writes_rd = 1'b0;
            end
            OPC_STORE: begin
                ext_op    = EXT_STORE;
                writes_rd = 1'b0;
            end
            default: begin
                ext_op    = EXT_ILL;
                writes_rd = 1'b0;
            end
        endcase
        is_load  = (ext_op == EXT_LOAD);
        is_store = (ext_op == EXT_STORE);
        is_csr   = (opcode == OPC_SYSTEM) && (funct3 != 3'b000);
    end

endmodule

// File: rtl/inst_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the NPC core.
// Optional INST_SEQ_PERF_EN adds 64-bit cycle and retired-instruction counters.
//
// state     | meaning
// ----------+---------------------------------------------------------
// RESET     | one idle cycle after reset release
// FETCH     | fetch request held until the IFU accepts it
// WAIT_I    | waiting for the instruction word, latched on arrival
// DECODE    | illegal -> TRAP, ebreak -> HALT, otherwise EXEC
// EXEC      | load/store -> MEM, everything else -> WB
// MEM       | LSU request held until accepted
// MEM_WAIT  | waiting for LSU response, bounded by MEM_TIMEOUT
// WB        | one-cycle PC/RF/CSR write strobes, back to FETCH
// HALT      | ebreak retired, absorbing until reset
// TRAP      | illegal opcode or LSU timeout, absorbing until reset
module inst_seq_ctrl
    import inst_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_inst,
    output logic [31:0] inst_q,
    output logic [3:0]  ext_op,
    output logic        lsu_req_valid,
    output logic        lsu_req_wen,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        pc_we,
    output logic        rf_we,
    output logic        csr_we,
    output logic        halt,
    output logic        trap,
    output logic [1:0]  trap_cause
`ifdef INST_SEQ_PERF_EN
    ,
    output logic [63:0] cyc_cnt,
    output logic [63:0] instret_cnt
`endif
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    state_e state_q, state_d;

    logic [TO_W-1:0] to_cnt_q;
    logic            to_expired;
    logic            is_load_q, is_store_q, writes_rd_q, is_csr_q;
    logic [3:0]      dec_ext;
    logic            dec_load, dec_store, dec_wrd, dec_csr;

    inst_class_dec u_dec (
        .opcode    (ifu_inst[6:0]),
        .funct3    (ifu_inst[14:12]),
        .ext_op    (dec_ext),
        .is_load   (dec_load),
        .is_store  (dec_store),
        .writes_rd (dec_wrd),
        .is_csr    (dec_csr)
    );

    // Down-counter loaded on LSU accept; terminal count 1 marks the last
    // MEM_WAIT cycle, so exactly MEM_TIMEOUT cycles are spent waiting.
    assign to_expired = (to_cnt_q == TO_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RESET;
            inst_q      <= '0;
            ext_op      <= EXT_ILL;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            writes_rd_q <= 1'b0;
            is_csr_q    <= 1'b0;
            to_cnt_q    <= '0;
            trap_cause  <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            if (state_q == ST_WAIT_I && ifu_rsp_valid) begin
                inst_q      <= ifu_inst;
                ext_op      <= dec_ext;
                is_load_q   <= dec_load;
                is_store_q  <= dec_store;
                writes_rd_q <= dec_wrd;
                is_csr_q    <= dec_csr;
            end
            if (state_q == ST_MEM && lsu_req_ready)
                to_cnt_q <= TO_W'(MEM_TIMEOUT);
            else if (state_q == ST_MEM_WAIT && to_cnt_q != '0)
                to_cnt_q <= to_cnt_q - TO_W'(1);
            if (state_q == ST_DECODE && ext_op == EXT_ILL)
                trap_cause <= CAUSE_ILLEGAL;
            if (state_q == ST_MEM_WAIT && !lsu_rsp_valid && to_expired)
                trap_cause <= CAUSE_LSU_TO;
        end
    end

    always_comb begin
        state_d       = state_q;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        lsu_req_wen   = 1'b0;
        pc_we         = 1'b0;
        rf_we         = 1'b0;
        csr_we        = 1'b0;
        halt          = 1'b0;
        trap          = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                ifu_req_valid = 1'b1;
                if (ifu_req_ready) state_d = ST_WAIT_I;
            end
            ST_WAIT_I: if (ifu_rsp_valid) state_d = ST_DECODE;
            ST_DECODE: begin
                if (ext_op == EXT_ILL)          state_d = ST_TRAP;
                else if (inst_q == INST_EBREAK) state_d = ST_HALT;
                else                            state_d = ST_EXEC;
            end
            ST_EXEC: state_d = (is_load_q || is_store_q) ? ST_MEM : ST_WB;
            ST_MEM: begin
                lsu_req_valid = 1'b1;
                lsu_req_wen   = is_store_q;
                if (lsu_req_ready) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (lsu_rsp_valid)   state_d = ST_WB;
                else if (to_expired) state_d = ST_TRAP;
            end
            ST_WB: begin
                pc_we   = 1'b1;
                rf_we   = writes_rd_q && (inst_q[11:7] != 5'd0);
                csr_we  = is_csr_q;
                state_d = ST_FETCH;
            end
            ST_HALT: halt = 1'b1;
            ST_TRAP: trap = 1'b1;
            default: state_d = ST_RESET;
        endcase
    end

`ifdef INST_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt     <= '0;
            instret_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 64'd1;
            if (state_q == ST_WB) instret_cnt <= instret_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Self-checking bench for inst_seq_ctrl: directed scenarios plus randomized
// instructions and bus delays, checked against a per-instruction outcome model.
module tb_inst_seq_ctrl;

    localparam int MT = 4;
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_inst, inst_q;
    logic [3:0]  ext_op;
    logic        lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_rsp_valid;
    logic        pc_we, rf_we, csr_we, halt, trap;
    logic [1:0]  trap_cause;
`ifdef INST_SEQ_PERF_EN
    logic [63:0] cyc_cnt, instret_cnt;
`endif

    inst_seq_ctrl #(.MEM_TIMEOUT(MT)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_inst      (ifu_inst),
        .inst_q        (inst_q),
        .ext_op        (ext_op),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_wen   (lsu_req_wen),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .pc_we         (pc_we),
        .rf_we         (rf_we),
        .csr_we        (csr_we),
        .halt          (halt),
        .trap          (trap),
        .trap_cause    (trap_cause)
`ifdef INST_SEQ_PERF_EN
        ,
        .cyc_cnt       (cyc_cnt),
        .instret_cnt   (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // per-run observations
    int         r_cyc, r_pc, r_rf, r_csr, r_lreq, r_wen_bad, r_hold_bad;
    logic [3:0] r_ext;
    bit         r_done;
    // perf model
    longint     exp_cycles, exp_retired;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: outcome of one instruction from the class table
    function automatic logic [3:0] ref_ext(input logic [31:0] inst);
        logic [6:0] opc = inst[6:0];
        case (opc)
            7'h37: return 4'd8;
            7'h17: return 4'd9;
            7'h6f: return 4'd7;
            7'h67: return 4'd0;
            7'h63: return 4'd6;
            7'h03: return 4'd1;
            7'h23: return 4'd5;
            7'h13: return 4'd2;
            7'h33: return 4'd10;
            7'h73: return 4'd4;
            default: return 4'd15;
        endcase
    endfunction

    function automatic int ref_rf(input logic [31:0] inst);
        logic [3:0] e = ref_ext(inst);
        bit cls = (e inside {4'd8, 4'd9, 4'd7, 4'd0, 4'd1, 4'd2, 4'd10, 4'd4});
        return (cls && inst[11:7] != 5'd0) ? 1 : 0;
    endfunction

    function automatic int ref_csr(input logic [31:0] inst);
        return (ref_ext(inst) == 4'd4 && inst[14:12] != 3'd0) ? 1 : 0;
    endfunction

    task automatic clear_inputs();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
    endtask

    // Acts as IFU and LSU for one instruction; starts at a negedge in FETCH,
    // ends at the negedge where a strobe, halt or trap is seen (or abort_at).
    task automatic run_instr(input logic [31:0] inst, input int ird, input int isd,
                             input int lrd, input int lsd, input int abort_at);
        int iw = 0, irc = 0, lw = 0, lrc = 0;
        bit i_acc = 0, i_done = 0, l_acc = 0, l_done = 0;
        bit prev_i = 0, prev_l = 0, capture = 0;
        bit wen_exp = (ref_ext(inst) == 4'd5);
        r_cyc = 0; r_pc = 0; r_rf = 0; r_csr = 0; r_lreq = 0;
        r_wen_bad = 0; r_hold_bad = 0; r_ext = 4'hx; r_done = 0;
        for (int c = 1; c <= 200; c++) begin
            if (capture) begin r_ext = ext_op; capture = 0; end
            if (prev_i && !ifu_req_valid) r_hold_bad++;
            if (prev_l && !lsu_req_valid) r_hold_bad++;
            if (pc_we) r_pc++;
            if (rf_we) r_rf++;
            if (csr_we) r_csr++;
            if (lsu_req_valid) begin
                r_lreq++;
                if (lsu_req_wen !== wen_exp) r_wen_bad++;
            end
            r_cyc = c;
            if (pc_we || halt || trap || c == abort_at) begin r_done = 1; break; end
            clear_inputs();
            ifu_inst = $urandom();
            if (i_acc && !i_done) begin
                if (irc >= isd) begin
                    ifu_rsp_valid = 1'b1; ifu_inst = inst; i_done = 1; capture = 1;
                end else irc++;
            end
            if (ifu_req_valid) begin
                if (iw >= ird) begin ifu_req_ready = 1'b1; i_acc = 1; end
                else iw++;
            end
            prev_i = ifu_req_valid && !ifu_req_ready;
            if (l_acc && !l_done) begin
                if (lrc >= lsd) begin lsu_rsp_valid = 1'b1; l_done = 1; end
                else lrc++;
            end
            if (lsu_req_valid) begin
                if (lw >= lrd) begin lsu_req_ready = 1'b1; l_acc = 1; end
                else lw++;
            end
            prev_l = lsu_req_valid && !lsu_req_ready;
            @(negedge clk);
        end
        clear_inputs();
        if (!r_done) chk("run_budget", 64'(r_done), 64'd1);
    endtask

    task automatic exec_check(input string tag, input logic [31:0] inst, input int ird,
                              input int isd, input int lrd, input int lsd);
        logic [3:0] e = ref_ext(inst);
        bit mem = (e == 4'd1 || e == 4'd5);
        int lat = 5 + ird + isd + (mem ? 2 + lrd + lsd : 0);
        run_instr(inst, ird, isd, lrd, lsd, 0);
        chk({tag, ":ext_op"}, 64'(r_ext), 64'(e));
        chk({tag, ":latency"}, 64'(r_cyc), 64'(lat));
        chk({tag, ":pc_we"}, 64'(r_pc), 64'd1);
        chk({tag, ":rf_we"}, 64'(r_rf), 64'(ref_rf(inst)));
        chk({tag, ":csr_we"}, 64'(r_csr), 64'(ref_csr(inst)));
        chk({tag, ":lsu_req_cycles"}, 64'(r_lreq), mem ? 64'(1 + lrd) : 64'd0);
        chk({tag, ":lsu_wen"}, 64'(r_wen_bad), 64'd0);
        chk({tag, ":valid_hold"}, 64'(r_hold_bad), 64'd0);
        chk({tag, ":inst_q"}, 64'(inst_q), 64'(inst));
        exp_cycles += lat;
        exp_retired++;
        @(negedge clk);
        chk({tag, ":refetch"}, 64'(ifu_req_valid), 64'd1);
        chk({tag, ":one_cycle_strobe"}, 64'(pc_we), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk({tag, ":ifu_req_valid"}, 64'(ifu_req_valid), 64'd0);
        chk({tag, ":lsu_req"}, 64'({lsu_req_valid, lsu_req_wen}), 64'd0);
        chk({tag, ":strobes"}, 64'({pc_we, rf_we, csr_we}), 64'd0);
        chk({tag, ":halt_trap"}, 64'({halt, trap, trap_cause}), 64'd0);
        chk({tag, ":ext_op"}, 64'(ext_op), 64'hf);
        chk({tag, ":inst_q"}, 64'(inst_q), 64'd0);
`ifdef INST_SEQ_PERF_EN
        chk({tag, ":perf_zero"}, cyc_cnt | instret_cnt, 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk({tag, ":to_fetch"}, 64'(ifu_req_valid), 64'd1);
        exp_cycles = 1;
        exp_retired = 0;
    endtask

    // Absorbing-state check: bus is tempted, nothing may be issued.
    task automatic idle_check(input string tag, input bit eh, input bit et, input logic [1:0] ec);
        int n_req = 0, n_str = 0, n_flag = 0;
        for (int c = 0; c < 5; c++) begin
            ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1;
            lsu_req_ready = 1'b1; lsu_rsp_valid = 1'b1;
            @(negedge clk);
            if (ifu_req_valid || lsu_req_valid) n_req++;
            if (pc_we || rf_we || csr_we) n_str++;
            if (halt !== eh || trap !== et || trap_cause !== ec) n_flag++;
        end
        clear_inputs();
        chk({tag, ":no_requests"}, 64'(n_req), 64'd0);
        chk({tag, ":no_strobes"}, 64'(n_str), 64'd0);
        chk({tag, ":sticky_flags"}, 64'(n_flag), 64'd0);
    endtask

    initial begin
        logic [6:0]  opcs [10];
        logic [31:0] inst;
        opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        rst = 1'b1;
        ifu_inst = '0;
        clear_inputs();
        exp_cycles = 0;
        exp_retired = 0;
        @(negedge clk);
        do_reset("reset0");

        exec_check("addi", 32'h00500093, 0, 0, 0, 0);
        exec_check("sw_delayed", 32'h0020a023, 0, 0, 3, 0);
        exec_check("lw_rsp_at_expiry", 32'h0000a103, 1, 1, 0, MT - 1);
        exec_check("csrrw", 32'h34029573, 0, 2, 0, 0);
        exec_check("beq_rd_bits", 32'h00208f63, 2, 0, 0, 0);
        exec_check("lui_x0", 32'h12345037, 0, 0, 0, 0);

        do_reset("reset_perf");
        for (int k = 0; k < 3; k++) exec_check("addi_b2b", 32'h00500093, 0, 0, 0, 0);
`ifdef INST_SEQ_PERF_EN
        chk("perf_cyc", cyc_cnt, 64'(exp_cycles));
        chk("perf_instret", instret_cnt, 64'(exp_retired));
`endif

        for (int n = 0; n < 40; n++) begin
            inst = $urandom();
            inst[6:0] = opcs[$urandom_range(0, 9)];
            if (inst == EBREAK) inst[20] = 1'b0;
            exec_check("rand", inst, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, MT - 1));
        end
`ifdef INST_SEQ_PERF_EN
        chk("perf_cyc_rand", cyc_cnt, 64'(exp_cycles));
        chk("perf_instret_rand", instret_cnt, 64'(exp_retired));
`endif

        // LSU never responds
        run_instr(32'h0000a103, 0, 0, 1, 1000, 0);
        chk("timeout:cycle", 64'(r_cyc), 64'(5 + 1 + MT + 1));
        chk("timeout:flags", 64'({halt, trap, trap_cause}), 64'b0_1_10);
        chk("timeout:pc_we", 64'(r_pc), 64'd0);
        idle_check("timeout", 1'b0, 1'b1, 2'd2);

        do_reset("reset_ill");
        run_instr(32'hdeadbeff, 1, 2, 0, 0, 0);
        chk("illegal:ext_op", 64'(r_ext), 64'hf);
        chk("illegal:cycle", 64'(r_cyc), 64'(4 + 1 + 2));
        chk("illegal:flags", 64'({halt, trap, trap_cause}), 64'b0_1_01);
        chk("illegal:pc_we", 64'(r_pc), 64'd0);
        idle_check("illegal", 1'b0, 1'b1, 2'd1);

        do_reset("reset_ebreak");
        run_instr(EBREAK, 0, 0, 0, 0, 0);
        chk("ebreak:ext_op", 64'(r_ext), 64'h4);
        chk("ebreak:cycle", 64'(r_cyc), 64'd4);
        chk("ebreak:flags", 64'({halt, trap, trap_cause}), 64'b1_0_00);
        chk("ebreak:pc_we", 64'(r_pc), 64'd0);
        idle_check("ebreak", 1'b1, 1'b0, 2'd0);

        do_reset("reset_mid");
        run_instr(32'h0000a103, 0, 0, 0, 1000, 7);
        chk("mid:in_mem_wait", 64'({lsu_req_valid, ifu_req_valid, pc_we, trap}), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ifu_rsp_valid = 1'b1; lsu_rsp_valid = 1'b1; ifu_inst = 32'h00700113;
        @(negedge clk);
        chk("stale:to_fetch", 64'({ifu_req_valid, lsu_req_valid}), 64'b10);
        @(negedge clk);
        chk("stale:still_fetch", 64'({ifu_req_valid, lsu_req_valid, pc_we}), 64'b100);
        chk("stale:inst_q", 64'(inst_q), 64'd0);
        chk("stale:ext_op", 64'(ext_op), 64'hf);
        clear_inputs();
        exp_cycles = 2;
        exp_retired = 0;
        exec_check("post_rst_addi", 32'h00a00193, 0, 0, 0, 0);
        exec_check("post_rst_lw", 32'h0041a203, 1, 0, 2, 1);
`ifdef INST_SEQ_PERF_EN
        chk("perf_cyc_post", cyc_cnt, 64'(exp_cycles));
        chk("perf_instret_post", instret_cnt, 64'(exp_retired));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
